// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave backed by a word-addressed on-chip memory.
// Zero-wait OKAY transfers; invalid or injected-error transfers get a two-cycle ERROR.
module ahb_lite_slave_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        ERR,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        HREADY
);

  localparam logic [1:0]  ST_OKAY  = 2'd0;
  localparam logic [1:0]  ST_ERR1  = 2'd1;
  localparam logic [1:0]  ST_ERR2  = 2'd2;
  localparam logic [31:0] LP_LIMIT = 32'(MEM_DEPTH * 4);

  logic [1:0]        r_state;
  logic              r_ph_vld;
  logic              r_write;
  logic [1:0]        r_size;
  logic [1:0]        r_boff;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0][7:0]   r_mem [MEM_DEPTH];

  logic       w_accept;
  logic       w_misalign;
  logic       w_err;
  logic       w_wr_en;
  logic [3:0] w_be;
  logic       w_unused;

  // Burst type, protection and the SEQ/NONSEQ distinction carry no behaviour here.
  assign w_unused = &{1'b0, HTRANS[0], HBURST, HPROT};

  assign HREADY   = (r_state != ST_ERR1);
  assign HRESP    = (r_state != ST_OKAY);
  assign w_accept = HREADY & HSEL & HTRANS[1];

  assign w_misalign = ((HSIZE == 3'd1) & HADDR[0]) |
                      ((HSIZE == 3'd2) & (HADDR[1:0] != 2'd0));
  assign w_err      = ERR | (HSIZE > 3'd2) | (HADDR >= LP_LIMIT) | w_misalign;

  // A pending data phase only exists for transfers that passed the error screen.
  assign w_wr_en = r_ph_vld & r_write;
  assign HRDATA  = (r_ph_vld & ~r_write) ? r_mem[r_idx] : 32'd0;

  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_boff;
      2'd1:    w_be = r_boff[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state  <= ST_OKAY;
      r_ph_vld <= 1'b0;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_boff   <= 2'd0;
      r_idx    <= '0;
    end else begin
      r_ph_vld <= 1'b0;
      if (w_accept) begin
        r_idx   <= HADDR[ADDR_W+1:2];
        r_boff  <= HADDR[1:0];
        r_size  <= HSIZE[1:0];
        r_write <= HWRITE;
        if (w_err) begin
          r_state <= ST_ERR1;
        end else begin
          r_state  <= ST_OKAY;
          r_ph_vld <= 1'b1;
        end
      end else if (r_state == ST_ERR1) begin
        r_state <= ST_ERR2;
      end else begin
        r_state <= ST_OKAY;
      end
    end
  end

  // Commit happens at the end of the write data phase, so a read accepted on
  // the same edge sees the new word in its own data phase.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      for (int l = 0; l < 4; l++)
        if (w_be[l]) r_mem[r_idx][l] <= HWDATA[8*l +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Scoreboard bench: the driver queues the expected per-cycle response, a monitor pops and compares.
module tb_ahb_lite_slave_mem;

  logic        clk = 1'b0;
  logic        resetn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        ERR;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADY;

  ahb_lite_slave_mem #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .resetn(resetn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .ERR(ERR), .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  // One bus cycle: inputs for the next edge plus the response expected right now.
  task automatic cyc(input logic rst, input logic sel, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic wr, input logic [1:0] trans,
                     input logic [2:0] size, input logic err,
                     input logic e_rdy, input logic e_resp, input logic [31:0] e_rdata,
                     input string name);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = rst; HSEL = sel; HADDR = addr; HWDATA = wdata; HWRITE = wr;
    HTRANS = trans; HSIZE = size; ERR = err;
    e.rdy = e_rdy; e.resp = e_resp; e.rdata = e_rdata; e.name = name;
    q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] wdata, input logic e_rdy, input logic e_resp,
                      input logic [31:0] e_rdata, input string name);
    cyc(1'b0, 1'b0, 32'h0, wdata, 1'b0, T_IDLE, 3'd2, 1'b0, e_rdy, e_resp, e_rdata, name);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (HREADY !== e.rdy || HRESP !== e.resp || HRDATA !== e.rdata) begin
        errors++;
        $display("FAIL %s: got HREADY=%b HRESP=%b HRDATA=%h, want HREADY=%b HRESP=%b HRDATA=%h",
                 e.name, HREADY, HRESP, HRDATA, e.rdy, e.resp, e.rdata);
      end
    end
  end

  initial begin
    resetn = 1'b1; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
    HTRANS = T_IDLE; HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'd0; ERR = 1'b0;

    // reset held for two edges, then read of 0x10
    cyc(1'b1, 1'b0, 32'h0,   32'h0, 1'b0, T_IDLE, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "reset1");
    cyc(1'b0, 1'b1, 32'h10,  32'h0, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "reset2");
    idle(32'h0, 1'b1, 1'b0, 32'h0, "rd10_zero");

    // word write then back-to-back read
    cyc(1'b0, 1'b1, 32'h04, 32'h0,        1'b1, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_a");
    cyc(1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "wr04_dphase");
    idle(32'h0, 1'b1, 1'b0, 32'hDEADBEEF, "rd04_word");

    // byte lane 2 over a full word
    cyc(1'b0, 1'b1, 32'h08, 32'h0,        1'b1, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_b");
    cyc(1'b0, 1'b1, 32'h0A, 32'h11223344, 1'b1, T_NSEQ, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, "wr08_dphase");
    cyc(1'b0, 1'b1, 32'h08, 32'h00AA0000, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "wr0A_dphase");
    idle(32'h0, 1'b1, 1'b0, 32'h11AA3344, "rd08_byte");

    // upper halfword of word 1
    cyc(1'b0, 1'b1, 32'h06, 32'h0,        1'b1, T_NSEQ, 3'd1, 1'b0, 1'b1, 1'b0, 32'h0, "idle_c");
    cyc(1'b0, 1'b1, 32'h04, 32'h55660000, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "wr06_dphase");
    idle(32'h0, 1'b1, 1'b0, 32'h5566BEEF, "rd04_half");

    // injected error on a write; a transfer offered during ERR1 must be ignored
    cyc(1'b0, 1'b1, 32'h0C, 32'h0,        1'b1, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_d");
    cyc(1'b0, 1'b1, 32'h0C, 32'hCAFEF00D, 1'b1, T_NSEQ, 3'd2, 1'b1, 1'b1, 1'b0, 32'h0, "wr0C_dphase");
    cyc(1'b0, 1'b1, 32'h00, 32'h12345678, 1'b1, T_NSEQ, 3'd2, 1'b0, 1'b0, 1'b1, 32'h0, "err_inj_err1");
    cyc(1'b0, 1'b1, 32'h0C, 32'hFFFFFFFF, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b1, 32'h0, "err_inj_err2");
    cyc(1'b0, 1'b1, 32'h00, 32'h0,        1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, "rd0C_unchanged");
    idle(32'h0, 1'b1, 1'b0, 32'h0, "rd00_err1_ignored");

    // out of range, recovery read accepted in ERR2
    cyc(1'b0, 1'b1, 32'h400, 32'h0, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_e");
    idle(32'h0, 1'b0, 1'b1, 32'h0, "oor_err1");
    cyc(1'b0, 1'b1, 32'h04,  32'h0, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b1, 32'h0, "oor_err2");
    idle(32'h0, 1'b1, 1'b0, 32'h5566BEEF, "rd04_after_err");

    // misaligned word
    cyc(1'b0, 1'b1, 32'h02, 32'h0, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_f");
    idle(32'h0, 1'b0, 1'b1, 32'h0, "misw_err1");
    idle(32'h0, 1'b1, 1'b1, 32'h0, "misw_err2");
    idle(32'h0, 1'b1, 1'b0, 32'h0, "misw_done");

    // invalid size, then misaligned halfword accepted in ERR2
    cyc(1'b0, 1'b1, 32'h04, 32'h0, 1'b0, T_NSEQ, 3'd3, 1'b0, 1'b1, 1'b0, 32'h0, "idle_g");
    idle(32'h0, 1'b0, 1'b1, 32'h0, "size_err1");
    cyc(1'b0, 1'b1, 32'h05, 32'h0, 1'b0, T_NSEQ, 3'd1, 1'b0, 1'b1, 1'b1, 32'h0, "size_err2");
    idle(32'h0, 1'b0, 1'b1, 32'h0, "mish_err1");
    idle(32'h0, 1'b1, 1'b1, 32'h0, "mish_err2");
    idle(32'h0, 1'b1, 1'b0, 32'h0, "mish_done");

    // IDLE, BUSY and deselected writes leave memory alone
    cyc(1'b0, 1'b1, 32'h04, 32'h0, 1'b1, T_IDLE, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_h");
    cyc(1'b0, 1'b1, 32'h04, 32'h0, 1'b1, T_BUSY, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "htrans_idle");
    cyc(1'b0, 1'b0, 32'h04, 32'h0, 1'b1, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "htrans_busy");
    cyc(1'b0, 1'b1, 32'h04, 32'h0, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "hsel_low");
    idle(32'h0, 1'b1, 1'b0, 32'h5566BEEF, "rd04_untouched");

    // pipelined burst at full rate
    cyc(1'b0, 1'b1, 32'h20, 32'h0,        1'b1, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_i");
    cyc(1'b0, 1'b1, 32'h24, 32'hA1A1A1A1, 1'b1, T_SEQ,  3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "burst_w0");
    cyc(1'b0, 1'b1, 32'h20, 32'hA2A2A2A2, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "burst_w1");
    cyc(1'b0, 1'b1, 32'h24, 32'h0,        1'b0, T_SEQ,  3'd2, 1'b0, 1'b1, 1'b0, 32'hA1A1A1A1, "burst_r0");
    idle(32'h0, 1'b1, 1'b0, 32'hA2A2A2A2, "burst_r1");

    // highest valid word
    cyc(1'b0, 1'b1, 32'h3FC, 32'h0,        1'b1, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_j");
    cyc(1'b0, 1'b1, 32'h3FC, 32'h0BADC0DE, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "wr3FC_dphase");
    idle(32'h0, 1'b1, 1'b0, 32'h0BADC0DE, "rd3FC");

    // reset during a write data phase clears memory and state
    cyc(1'b0, 1'b1, 32'h30, 32'h0,        1'b1, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_k");
    cyc(1'b1, 1'b0, 32'h0,  32'h77777777, 1'b0, T_IDLE, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "wr30_dphase");
    cyc(1'b0, 1'b1, 32'h04, 32'h0,        1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "midrst");
    cyc(1'b0, 1'b1, 32'h30, 32'h0,        1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "rd04_cleared");
    idle(32'h0, 1'b1, 1'b0, 32'h0, "rd30_dropped");

    // reset during ERR1 returns to OKAY
    cyc(1'b0, 1'b1, 32'h400, 32'h0, 1'b0, T_NSEQ, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, "idle_l");
    cyc(1'b1, 1'b0, 32'h0,   32'h0, 1'b0, T_IDLE, 3'd2, 1'b0, 1'b0, 1'b1, 32'h0, "rst_err1");
    idle(32'h0, 1'b1, 1'b0, 32'h0, "err_aborted");
    idle(32'h0, 1'b1, 1'b0, 32'h0, "okay_after_rst");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
